mac6x6_accumulator: RTL and testbench
=====================================

# mac6x6_accumulator

Sequential multiply-accumulate stage that sits directly downstream of the 6x6 carry-save multiplier (`multiply6x6`). It accepts a burst of `len` operand pairs over a valid/ready handshake and registers the operands. It feeds them to one internal `multiply6x6` instance, registers the 12-bit unsigned product, and sums the products into a saturating accumulator. The final sum is presented on a valid/ready result port. This turns the combinational multiplier into a pipelined dot-product unit for the lab datapath.

## Interface
- `ACC_W`, 16, accumulator and result width in bits; legal range 12–24.
- `LEN_W`, 4, width of the burst-length input; maximum burst is 2^LEN_W−1 terms.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a burst; sampled only in IDLE.
- `len`  in  LEN_W  number of operand pairs in the burst; sampled with `start`.
- `in_valid`  in  1  operand pair on `a`/`b` is valid.
- `in_ready`  out  1  block accepts an operand pair this cycle.
- `a`, `b`  in  6 each  unsigned operands.
- `busy`  out  1  high in RUN and DONE.
- `out_valid`  out  1  `acc_out` holds the final sum.
- `out_ready`  in  1  consumer accepts the result.
- `acc_out`  out  ACC_W  accumulated sum.
- `overflow`  out  1  sticky flag; the sum saturated during this burst.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE → RUN occurs on `start`=1. At that edge the block:
  - latches `len` into `remaining`;
  - clears the accumulator, `overflow` and both pipeline valid bits.
- IDLE → DONE occurs on `start`=1 with `len`=0. The accumulator is cleared and no beats are taken.
- In RUN, `in_ready` = (`remaining` ≠ 0). A beat is accepted when `in_valid` and `in_ready` are both high. On acceptance:
  - `a` and `b` load into the operand registers;
  - `s1_valid` is set to 1;
  - `remaining` decrements.
- Stage 2 loads the 12-bit product of the operand registers into the product register. `s2_valid` takes the value of `s1_valid`.
- Stage 3 updates the accumulator when `s2_valid`=1. The new value is acc + zero-extended product.
  - If the true sum exceeds 2^ACC_W−1, the accumulator holds all-ones and `overflow` is set.
  - `overflow` stays set until the next `start`. A saturated accumulator remains all-ones.
- RUN → DONE occurs when `remaining`=0, `s1_valid`=0, and `s2_valid` is being consumed (or is already 0). This means the last product is accumulated on the same edge the state enters DONE.
- In DONE:
  - `out_valid`=1;
  - `acc_out` and `overflow` are held stable;
  - DONE → IDLE when `out_ready`=1.
- `start` is ignored outside IDLE. `in_valid` is ignored when `in_ready`=0.
- `acc_out` always reflects the accumulator register. It is valid to sample only while `out_valid`=1.
- Product width: 63×63 = 3969 fits in 12 bits. With the default parameters the largest possible sum is 15×3969 = 59535, so overflow cannot occur. Saturation is exercised with `ACC_W`=12.

## Timing
- Reset values: state=IDLE, `in_ready`=0, `busy`=0, `out_valid`=0, `acc_out`=0, `overflow`=0. Reset also clears `remaining` and both pipeline valid bits.
- `rst` asserted mid-burst aborts immediately and asynchronously. Nothing is output for the aborted burst.
- Operands are fully registered. The multiplier path is combinational between the operand register and the product register.
- Latency: when the last beat is accepted at edge E0, the product is registered at E1 and accumulated at E2. The state enters DONE at E2, and `out_valid` is high in the cycle after E2.
  - Beat presented in cycle 0 → `out_valid` in cycle 3.
- Throughput is one beat per cycle when `in_valid` is held high. Gaps in `in_valid` insert bubbles without corrupting the sum.
- `out_valid` and `out_ready` high in the same cycle: the result is taken, and the state is IDLE next cycle. A new `start` can be accepted in that IDLE cycle; there is no combinational start-in-DONE path.
- `in_ready` is registered-state based only (`remaining` ≠ 0 in RUN). It has no combinational dependence on `in_valid`.

## Test plan
- Reset, then `start` with `len`=3 and pairs (1,1), (63,63), (5,7) back-to-back → `out_valid` in cycle 3 after the last beat, `acc_out`=4005, `overflow`=0.
- `len`=4 with pairs (2,3) ×4 and a one-cycle `in_valid` gap after each beat, plus `out_ready` held low 5 cycles → `acc_out`=24 held stable until `out_ready`, then IDLE; `in_ready`=0 throughout DONE.
- `len`=0 → `out_valid` one cycle after `start`, `acc_out`=0; `start` pulsed during RUN of a following burst is ignored.
- `ACC_W`=12, `len`=2, pairs (63,63), (63,63) → `acc_out`=4095, `overflow`=1. The next burst, `len`=1 with pair (1,2), gives `acc_out`=2 and `overflow`=0.
- Assert `rst` after 2 of 5 beats are accepted → all outputs 0 immediately. A new `len`=1 burst with pair (10,10) then gives `acc_out`=100.
- Random 200 bursts (`len` 0–15, random `a`/`b`, random valid/ready gaps) → `acc_out` equals the golden Σa·b for every burst.

Source files
------------

// File: rtl/mac6x6_accumulator.sv
// rtl/mac6x6_accumulator.sv - pipelined saturating multiply-accumulate stage around a 6x6 multiplier

// Combinational 6x6 unsigned multiplier built as a shift-and-add partial product array.
module multiply6x6 (
    input  logic [5:0]  a,
    input  logic [5:0]  b,
    output logic [11:0] p
);

    // Sum the six shifted partial products.
    always_comb begin
        p = '0;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) begin
                p = p + (12'(a) << i);
            end
        end
    end

endmodule

// Burst dot-product unit: operand regs -> product reg -> saturating accumulator.
module mac6x6_accumulator #(
    parameter int ACC_W = 16,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       a,
    input  logic [5:0]       b,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] remaining;
    logic [5:0]       opa;
    logic [5:0]       opb;
    logic             s1_valid;
    logic [11:0]      prod;
    logic             s2_valid;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [11:0]      mult_p;
    logic             accept;
    logic [ACC_W:0]   sum_ext;

    multiply6x6 u_mult (
        .a (opa),
        .b (opb),
        .p (mult_p)
    );

    assign accept  = (state == S_RUN) && in_valid && (remaining != '0);
    assign sum_ext = {1'b0, acc} + {{(ACC_W + 1 - 12){1'b0}}, prod};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the last product is accumulated on the edge that enters DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if ((remaining == '0) && !s1_valid) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        in_ready  = (state == S_RUN) && (remaining != '0);
        busy      = (state != S_IDLE);
        out_valid = (state == S_DONE);
    end

    assign acc_out  = acc;
    assign overflow = ovf;

    // Datapath: burst setup in IDLE, three-stage pipeline in RUN, everything held in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            opa       <= '0;
            opb       <= '0;
            s1_valid  <= 1'b0;
            prod      <= '0;
            s2_valid  <= 1'b0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        remaining <= len;
                        acc       <= '0;
                        ovf       <= 1'b0;
                        s1_valid  <= 1'b0;
                        s2_valid  <= 1'b0;
                    end
                end
                S_RUN: begin
                    s1_valid <= accept;
                    if (accept) begin
                        opa       <= a;
                        opb       <= b;
                        remaining <= remaining - LEN_W'(1);
                    end
                    prod     <= mult_p;
                    s2_valid <= s1_valid;
                    if (s2_valid) begin
                        if (sum_ext[ACC_W]) begin
                            acc <= '1;
                            ovf <= 1'b1;
                        end else begin
                            acc <= sum_ext[ACC_W-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac6x6_accumulator.sv
// tb/tb_mac6x6_accumulator.sv - directed and randomized self-checking bench for mac6x6_accumulator
module tb_mac6x6_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  len;
    logic        in_valid;
    logic [5:0]  a;
    logic [5:0]  b;
    logic        out_ready;

    logic        in_ready;
    logic        busy;
    logic        out_valid;
    logic [15:0] acc_out;
    logic        overflow;

    logic        in_ready12;
    logic        busy12;
    logic        out_valid12;
    logic [11:0] acc_out12;
    logic        overflow12;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mac6x6_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .overflow  (overflow)
    );

    mac6x6_accumulator #(.ACC_W(12), .LEN_W(4)) dut12 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready12),
        .a         (a),
        .b         (b),
        .busy      (busy12),
        .out_valid (out_valid12),
        .out_ready (out_ready),
        .acc_out   (acc_out12),
        .overflow  (overflow12)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [3:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beat(input logic [5:0] x, input logic [5:0] y, input int gap);
        int k;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        a = x;
        b = y;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk("beat_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int k;
        k = 0;
        while (!out_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int l;
        int sum;
        int x;
        int y;
        rst = 1'b1;
        start = 1'b0;
        len = '0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        out_ready = 1'b0;
        #1;
        chk("reset_outputs", 32'({in_ready, busy, out_valid, overflow, acc_out}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back burst and three-cycle latency.
        do_start(4'd3);
        beat(6'd1, 6'd1, 0);
        beat(6'd63, 6'd63, 0);
        beat(6'd5, 6'd7, 0);
        chk("lat_c1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_c2", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_c3", 32'(out_valid), 32'd1);
        chk("sum_4005", 32'(acc_out), 32'd4005);
        chk("ovf_4005", 32'(overflow), 32'd0);
        take();
        chk("idle_after_take", 32'({out_valid, busy}), 32'd0);

        // Gapped beats with back-pressure on the result.
        do_start(4'd4);
        beat(6'd2, 6'd3, 0);
        beat(6'd2, 6'd3, 1);
        beat(6'd2, 6'd3, 1);
        beat(6'd2, 6'd3, 1);
        wait_out();
        for (int i = 0; i < 5; i++) begin
            chk("hold_acc", 32'(acc_out), 32'd24);
            chk("hold_state", 32'({out_valid, in_ready, busy}), 32'b101);
            @(negedge clk);
        end
        take();
        chk("idle_after_hold", 32'({out_valid, busy}), 32'd0);

        // Zero-length burst, then start pulsed mid-burst.
        do_start(4'd0);
        chk("len0_valid", 32'(out_valid), 32'd1);
        chk("len0_acc", 32'(acc_out), 32'd0);
        take();
        do_start(4'd2);
        beat(6'd4, 6'd5, 0);
        start = 1'b1;
        len = 4'd9;
        beat(6'd6, 6'd7, 0);
        start = 1'b0;
        chk("ignored_start_ready", 32'({in_ready, busy}), 32'b01);
        wait_out();
        chk("ignored_start_sum", 32'(acc_out), 32'd62);
        take();

        // Saturation on the 12-bit instance, then a clean burst.
        do_start(4'd2);
        beat(6'd63, 6'd63, 0);
        beat(6'd63, 6'd63, 0);
        wait_out();
        chk("sat_acc12", 32'(acc_out12), 32'd4095);
        chk("sat_ovf12", 32'(overflow12), 32'd1);
        chk("nosat_acc16", 32'(acc_out), 32'd7938);
        chk("nosat_ovf16", 32'(overflow), 32'd0);
        take();
        do_start(4'd1);
        beat(6'd1, 6'd2, 0);
        wait_out();
        chk("post_sat_acc12", 32'(acc_out12), 32'd2);
        chk("post_sat_ovf12", 32'(overflow12), 32'd0);
        take();

        // Asynchronous abort mid-burst.
        do_start(4'd5);
        beat(6'd10, 6'd1, 0);
        beat(6'd10, 6'd2, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_outputs", 32'({in_ready, busy, out_valid, overflow, acc_out}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start(4'd1);
        beat(6'd10, 6'd10, 0);
        wait_out();
        chk("after_abort_acc", 32'(acc_out), 32'd100);
        take();

        // Randomized bursts against a running golden sum.
        for (int n = 0; n < 200; n++) begin
            l = $urandom_range(0, 15);
            sum = 0;
            do_start(4'(l));
            for (int j = 0; j < l; j++) begin
                x = $urandom_range(0, 63);
                y = $urandom_range(0, 63);
                sum += x * y;
                beat(6'(x), 6'(y), $urandom_range(0, 2));
            end
            wait_out();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            chk("rand_sum", 32'(acc_out), 32'(sum));
            take();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
